seg_scan_mux: RTL and testbench
===============================

Name: seg_scan_mux

Overview:
Parametrised time-multiplexed driver for common-anode 7-segment displays with N hex digits.
- Registered outputs throughout.
- Per-digit decimal point and blanking.
- 16-step brightness PWM.
- Tear-free data capture: input data is latched only at frame boundaries.
- Sits between the measurement and formatting logic (e.g. sensor readout) and the board's digit-select and segment pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 1..8.
- CLK_DIV, 50000: clocks per digit slot. Must be a multiple of 16 and at least 32.
- SUB_DIV, CLK_DIV/16: clocks per PWM sub-phase. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  1 = light decimal point of digit i
- blank_in  in  NUM_DIGITS  1 = digit i dark (segments and select both off)
- brightness  in  4  PWM duty; digit lit for (brightness+1)/16 of its slot
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- cs  out  NUM_DIGITS  active-low digit selects; at most one bit low
- frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0

Behaviour:
Reset (rst_n low at posedge clk):
- seg=8'hFF, cs=all 1s, frame_done=0.
- Prescaler, sub-phase counter, phase and digit index all cleared to 0.
- Shadow registers (data, dp, blank) cleared to 0.
- Reset asserted mid-slot or mid-frame takes effect on the next edge. No partial digit persists.

Timing chain:
- Prescaler counts 0..SUB_DIV-1. sub_tick asserts when prescaler==SUB_DIV-1.
- Phase (4 bits) increments on sub_tick. slot_tick = sub_tick && phase==15.
- On slot_tick, digit index increments, wrapping NUM_DIGITS-1 -> 0. Each slot is exactly CLK_DIV clocks.

Capture:
- On slot_tick with index==NUM_DIGITS-1, data, dp_in and blank_in are copied into the shadow registers.
- frame_done pulses high in the same cycle as that copy.
- Inputs changing at any other time have no visible effect until the next frame boundary.

Display decode, from shadow values for the current index:
- nibble to 7-segment code (active low): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- seg[7] is forced 0 when the shadow dp bit is 1.
- enable = (phase <= brightness) && !shadow_blank[index].
- brightness is sampled live, with no shadowing.

Outputs:
- seg and cs are registered: 1-cycle latency from index/phase change to pins.
- enable=1: cs = ~(1<<index), seg = decoded value.
- enable=0: cs = all 1s, seg = 8'hFF.
- brightness=15 gives 100% duty; brightness=0 gives 1/16.

Glitch rule: on the cycle the index changes, cs never shows two low bits.

Optional Feature:
Macro: SEG_SCAN_LZ_SUPPRESS_EN

Defined (leading-zero suppression):
- At capture, starting from digit NUM_DIGITS-1 downward, each digit whose nibble is 0 and whose dp bit is 0 is treated as blanked.
- Suppression stops at the first nonzero nibble or set dp bit.
- Digit 0 is never suppressed.
- Suppression is ORed into the shadow blank bits.

Undefined: zeros display as "0". Shadow blank equals blank_in only.

Test Plan:
1. Bench setup: NUM_DIGITS=4, CLK_DIV=32. Hold rst_n=0 for 3 clocks, then release -> seg=FF, cs=F, frame_done=0 during reset. The first frame shows shadow 0000, so digit 0 displays C0 with cs=E, one cycle after reset release.
2. data=16'h12A9, brightness=15, dp_in=0, blank_in=0; run 2 frames -> in the second frame slots show cs=E/seg=90, cs=D/seg=88, cs=B/seg=A4, cs=7/seg=F9. Each slot lasts 32 clocks. frame_done pulses once every 128 clocks.
3. brightness=3, data=16'h0008 -> per slot, cs low for exactly 8 of 32 clocks (phases 0-3), then cs=F and seg=FF for the remaining 24 clocks.
4. Change data from 16'h1111 to 16'h2222 mid-frame (during slot 1) -> remaining slots of that frame still show F9. All four digits show A4 only after the next frame_done.
5. dp_in=4'b0010, blank_in=4'b1000, data=16'h5555 -> digit 1 seg=12, digit 0 and digit 2 seg=92, digit 3 cs=F for its whole slot. Assert rst_n=0 mid-slot -> seg=FF and cs=F on the next edge, and index restarts at 0.
6. With SEG_SCAN_LZ_SUPPRESS_EN defined: data=16'h0040 -> digits 3 and 2 dark, digit 1 seg=99, digit 0 seg=C0. data=16'h0000 -> only digit 0 lit, seg=C0.

Source files
------------

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_mux: hex/dp/blank/brightness in, registered segment/select pins out.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [3:0]              brightness;
    logic [7:0]              seg;
    logic [NUM_DIGITS-1:0]   cs;
    logic                    frame_done;

    modport master (
        output data, dp_in, blank_in, brightness,
        input  seg, cs, frame_done
    );

    modport slave (
        input  data, dp_in, blank_in, brightness,
        output seg, cs, frame_done
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with 16-step PWM and frame-boundary data capture.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int SUB_DIV    = CLK_DIV / 16
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    logic [PW-1:0]         presc;
    logic [3:0]            phase;
    logic [IW-1:0]         index;
    logic [DW-1:0]         shadow_data;
    logic [NUM_DIGITS-1:0] shadow_dp;
    logic [NUM_DIGITS-1:0] shadow_blank;
    logic [7:0]            seg_r;
    logic [NUM_DIGITS-1:0] cs_r;
    logic                  frame_done_r;

    logic                  sub_tick;
    logic                  slot_tick;
    logic                  last_digit;
    logic                  frame_tick;
    logic [NUM_DIGITS-1:0] blank_next;
    logic [NUM_DIGITS-1:0] sel;
    logic [3:0]            nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  lit;
    logic [7:0]            decoded;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 8'hC0;
            4'h1: hex_to_seg = 8'hF9;
            4'h2: hex_to_seg = 8'hA4;
            4'h3: hex_to_seg = 8'hB0;
            4'h4: hex_to_seg = 8'h99;
            4'h5: hex_to_seg = 8'h92;
            4'h6: hex_to_seg = 8'h82;
            4'h7: hex_to_seg = 8'hF8;
            4'h8: hex_to_seg = 8'h80;
            4'h9: hex_to_seg = 8'h90;
            4'hA: hex_to_seg = 8'h88;
            4'hB: hex_to_seg = 8'h83;
            4'hC: hex_to_seg = 8'hC6;
            4'hD: hex_to_seg = 8'hA1;
            4'hE: hex_to_seg = 8'h86;
            default: hex_to_seg = 8'h8E;
        endcase
    endfunction

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    // Walk down from the top digit; the run of suppressed digits ends at the
    // first nonzero nibble or lit decimal point. Digit 0 is never touched.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [DW-1:0] d,
                                                      input logic [NUM_DIGITS-1:0] dp);
        logic                  run;
        logic [NUM_DIGITS-1:0] mask;
        run  = 1'b1;
        mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'h0 || dp[i]) run = 1'b0;
            mask[i] = run;
        end
        return mask;
    endfunction

    assign blank_next = bus.blank_in | lz_mask(bus.data, bus.dp_in);
`else
    assign blank_next = bus.blank_in;
`endif

    assign sub_tick   = (presc == PW'(SUB_DIV - 1));
    assign slot_tick  = sub_tick && (phase == 4'd15);
    assign last_digit = (index == IW'(NUM_DIGITS - 1));
    assign frame_tick = slot_tick && last_digit;

    always_comb begin
        sel       = '0;
        nib       = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (index == IW'(i)) begin
                sel[i]    = 1'b1;
                nib       = shadow_data[4*i +: 4];
                cur_dp    = shadow_dp[i];
                cur_blank = shadow_blank[i];
            end
        end
        lit     = (phase <= bus.brightness) && !cur_blank;
        decoded = hex_to_seg(nib) & {~cur_dp, 7'h7F};
    end

    // Timing chain, frame capture and registered pin stage share one edge;
    // cs is derived from the single registered index so it stays one-hot-low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc        <= '0;
            phase        <= 4'd0;
            index        <= '0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
            seg_r        <= 8'hFF;
            cs_r         <= '1;
            frame_done_r <= 1'b0;
        end else begin
            presc <= sub_tick ? '0 : presc + PW'(1);
            if (sub_tick) phase <= phase + 4'd1;
            if (slot_tick) index <= last_digit ? '0 : index + IW'(1);
            frame_done_r <= frame_tick;
            if (frame_tick) begin
                shadow_data  <= bus.data;
                shadow_dp    <= bus.dp_in;
                shadow_blank <= blank_next;
            end
            seg_r <= lit ? decoded : 8'hFF;
            cs_r  <= lit ? ~sel : '1;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.cs         = cs_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (NUM_DIGITS=4, CLK_DIV=32); table of frames plus tear and reset sequences.
module tb_seg_scan_mux;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seg_scan_mux #(.NUM_DIGITS(4), .CLK_DIV(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  br;
        logic [31:0] segs;   // {d3,d2,d1,d0} expected lit segment codes
        logic [3:0]  lit;    // digits expected to light at all
    } vec_t;

    vec_t vecs [8];
    int total = 0;
    int bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pins(input string name, input logic [7:0] es,
                              input logic [3:0] ec, input logic ef);
        total++;
        if (bus.seg !== es || bus.cs !== ec || bus.frame_done !== ef) begin
            bad++;
            $display("FAIL %s: seg=%h cs=%h fd=%b, want seg=%h cs=%h fd=%b",
                     name, bus.seg, bus.cs, bus.frame_done, es, ec, ef);
        end
    endtask

    // Checks one full frame cycle by cycle; expects to start right after a frame_done sample.
    task automatic check_frame(input string name, input logic [31:0] segs,
                               input logic [3:0] lit, input logic [3:0] br,
                               input int chg_at, input logic [15:0] chg_data);
        for (int j = 0; j < 128; j++) begin
            int slot;
            int ph;
            logic [7:0] es;
            logic [3:0] ec;
            if (j == chg_at) bus.data = chg_data;
            tick();
            slot = j / 32;
            ph   = (j % 32) / 2;
            if (lit[slot] && ph <= int'(br)) begin
                es = segs[8*slot +: 8];
                ec = ~(4'b0001 << slot);
            end else begin
                es = 8'hFF;
                ec = 4'hF;
            end
            check_pins($sformatf("%s cyc%0d", name, j), es, ec, j == 127);
        end
    endtask

    task automatic wait_frame(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            tick();
            if (bus.frame_done === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: frame_done=0 after 200 cycles, want a pulse", name);
        end
    endtask

    initial begin
        vecs[0] = '{16'h12A9, 4'h0, 4'h0, 4'hF, 32'hF9A48890, 4'hF};
        vecs[1] = '{16'h0008, 4'h0, 4'h0, 4'h3, 32'hC0C0C080, LZ ? 4'h1 : 4'hF};
        vecs[2] = '{16'h5555, 4'h2, 4'h8, 4'hF, 32'h92921292, 4'h7};
        vecs[3] = '{16'hFEDC, 4'h9, 4'h0, 4'h7, 32'h0E86A146, 4'hF};
        vecs[4] = '{16'h3470, 4'h0, 4'h0, 4'h0, 32'hB099F8C0, 4'hF};
        vecs[5] = '{16'h0040, 4'h0, 4'h0, 4'hF, 32'hC0C099C0, LZ ? 4'h3 : 4'hF};
        vecs[6] = '{16'h0000, 4'h0, 4'h0, 4'hF, 32'hC0C0C0C0, LZ ? 4'h1 : 4'hF};
        vecs[7] = '{16'h0000, 4'h4, 4'h0, 4'hF, 32'hC040C0C0, LZ ? 4'h7 : 4'hF};

        bus.data       = 16'h0000;
        bus.dp_in      = 4'h0;
        bus.blank_in   = 4'h0;
        bus.brightness = 4'hF;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_pins($sformatf("reset%0d", i), 8'hFF, 4'hF, 1'b0);
        end
        rst_n = 1'b1;
        check_frame("first_frame", 32'hC0C0C0C0, 4'hF, 4'hF, -1, 16'h0);

        for (int v = 0; v < 8; v++) begin
            bus.data       = vecs[v].data;
            bus.dp_in      = vecs[v].dp;
            bus.blank_in   = vecs[v].blank;
            bus.brightness = vecs[v].br;
            wait_frame($sformatf("vec%0d_wait", v));
            check_frame($sformatf("vec%0d", v), vecs[v].segs, vecs[v].lit,
                        vecs[v].br, -1, 16'h0);
        end

        // Mid-frame data change must not tear the frame being shown.
        bus.data       = 16'h1111;
        bus.dp_in      = 4'h0;
        bus.blank_in   = 4'h0;
        bus.brightness = 4'hF;
        wait_frame("tear_wait");
        check_frame("tear_old", 32'hF9F9F9F9, 4'hF, 4'hF, 40, 16'h2222);
        check_frame("tear_new", 32'hA4A4A4A4, 4'hF, 4'hF, -1, 16'h0);

        // Reset in the middle of slot 1, then index restarts at digit 0.
        for (int i = 0; i < 45; i++) tick();
        rst_n = 1'b0;
        tick();
        check_pins("midreset_hold", 8'hFF, 4'hF, 1'b0);
        rst_n = 1'b1;
        tick();
        check_pins("midreset_digit0", 8'hC0, 4'hE, 1'b0);
        for (int i = 0; i < 31; i++) tick();
        tick();
        check_pins("midreset_digit1", 8'hC0, 4'hD, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
